// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin front end sharing one combinational FP add/sub datapath
// Optional sticky exception flags are built when FP_ARB_STICKY_EN is defined.
module fp_add_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  output logic             dp_sub,
  input  logic [31:0]      dp_result,
  input  logic             dp_overflow,
  input  logic             dp_underflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic             rsp_nan,
  output logic             flags_ovf,
  output logic             flags_udf,
  output logic             flags_nan,
  input  logic             flags_clr
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_n;
  logic             last_gnt;
  logic [31:0]      op_a, op_b;
  logic             op_sub;
  logic [TAG_W-1:0] op_tag;
  logic             op_id;
  logic             window, gnt0, gnt1, acc0, acc1, accept;
  logic             dp_nan;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (rsp_ready) state_n = accept ? EXEC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // last_gnt names the requester granted most recently; a tie goes to the other one.
  always_comb begin
    window     = (state == IDLE) || ((state == RESP) && rsp_ready);
    gnt0       = req0_valid && (!req1_valid || last_gnt);
    gnt1       = req1_valid && (!req0_valid || !last_gnt);
    req0_ready = !rst && window && gnt0;
    req1_ready = !rst && window && gnt1;
    acc0       = req0_ready && req0_valid;
    acc1       = req1_ready && req1_valid;
    accept     = acc0 || acc1;
    rsp_valid  = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      op_tag   <= '0;
      op_id    <= 1'b0;
    end else if (accept) begin
      last_gnt <= acc1;
      op_id    <= acc1;
      op_a     <= acc1 ? req1_a   : req0_a;
      op_b     <= acc1 ? req1_b   : req0_b;
      op_sub   <= acc1 ? req1_sub : req0_sub;
      op_tag   <= acc1 ? req1_tag : req0_tag;
    end
  end

  assign dp_a   = op_a;
  assign dp_b   = op_b;
  assign dp_sub = op_sub;
  assign dp_nan = (dp_result[30:23] == 8'hFF) && (dp_result[22:0] != 23'd0);

  // Response registers load only as EXEC hands over to RESP, so they hold through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id        <= 1'b0;
      rsp_tag       <= '0;
      rsp_result    <= '0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
      rsp_nan       <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id        <= op_id;
      rsp_tag       <= op_tag;
      rsp_result    <= dp_result;
      rsp_overflow  <= dp_overflow;
      rsp_underflow <= dp_underflow;
      rsp_nan       <= dp_nan;
    end
  end

`ifdef FP_ARB_STICKY_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid && rsp_ready;

  // A flag raised by the handshake survives a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_ovf <= 1'b0;
      flags_udf <= 1'b0;
      flags_nan <= 1'b0;
    end else begin
      flags_ovf <= (flags_ovf && !flags_clr) || (rsp_hs && rsp_overflow);
      flags_udf <= (flags_udf && !flags_clr) || (rsp_hs && rsp_underflow);
      flags_nan <= (flags_nan && !flags_clr) || (rsp_hs && rsp_nan);
    end
  end
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign flags_ovf = 1'b0;
  assign flags_udf = 1'b0;
  assign flags_nan = 1'b0;
`endif

endmodule
